// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and stop-reason codes for run_controller
package run_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;
  localparam logic [1:0] REASON_NONE  = 2'd0;
  localparam logic [1:0] REASON_LIMIT = 2'd1;
  localparam logic [1:0] REASON_HALT  = 2'd2;
  localparam logic [1:0] REASON_ABORT = 2'd3;
endpackage

// File: rtl/run_controller_halt_detector.sv
// halt_detector: flags a halt once pc has stayed unchanged for HALT_REPEAT consecutive comparisons
module halt_detector #(
  parameter int ADDR_W      = 16,
  parameter int HALT_REPEAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              halted_o
);
  logic [ADDR_W-1:0] prev_q;
  logic              prev_vld_q;
  logic [31:0]       stable_q, stable_d;
  logic              same;
  // prev_vld_q drops outside RUN so the first cycle of every run has no history
  assign same     = en_i && prev_vld_q && (pc_i == prev_q);
  assign stable_d = same ? stable_q + 32'd1 : 32'd0;
  assign halted_o = (HALT_REPEAT != 0) && same && (stable_d == 32'(HALT_REPEAT));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      stable_q   <= '0;
    end else begin
      prev_q     <= pc_i;
      prev_vld_q <= en_i;
      stable_q   <= stable_d;
    end
endmodule

// File: rtl/run_controller.sv
// run_controller: gates CPU execution, stops on limit/halt/abort, then streams a RAM window out
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MAX_CYCLES  = 10,
  parameter int HALT_REPEAT = 4,
  parameter int DUMP_BASE   = 0,
  parameter int DUMP_LEN    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              cpu_run,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic [31:0]       cycle_count,
  output logic              done,
  output logic [1:0]        stop_reason
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(DUMP_BASE);
  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0]        reason_q, reason_d;
  logic              dump_valid_q;
  logic [ADDR_W-1:0] dump_index_q;
  logic              halted;
  halt_detector #(.ADDR_W(ADDR_W), .HALT_REPEAT(HALT_REPEAT)) u_halt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == RUN),
    .pc_i     (pc),
    .halted_o (halted)
  );
  assign cpu_run     = state_q == RUN;
  assign done        = state_q == DONE;
  assign mem_rd_en   = (state_q == DUMP) && (rd_cnt_q < 32'(DUMP_LEN));
  assign mem_rd_addr = mem_rd_en ? BASE + rd_cnt_q[ADDR_W-1:0] : '0;
  assign dump_valid  = dump_valid_q;
  assign dump_index  = dump_index_q;
  // read data only arrives in the cycle after the strobe, so it passes straight through
  assign dump_data   = dump_valid_q ? mem_rd_data : '0;
  assign cycle_count = cnt_q;
  assign stop_reason = reason_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reason_d = reason_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d  = RUN;
        cnt_d    = '0;
        reason_d = REASON_NONE;
      end
      RUN: begin
        cnt_d    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        reason_d = abort ? REASON_ABORT :
                   halted ? REASON_HALT :
                   (MAX_CYCLES != 0 && cnt_d == 32'(MAX_CYCLES)) ? REASON_LIMIT : REASON_NONE;
        if (reason_d != REASON_NONE) begin
          state_d  = (DUMP_LEN == 0) ? DONE : DUMP;
          rd_cnt_d = '0;
        end
      end
      DUMP: begin
        rd_cnt_d = mem_rd_en ? rd_cnt_q + 32'd1 : rd_cnt_q;
        if (!mem_rd_en && dump_valid_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      reason_q     <= REASON_NONE;
      rd_cnt_q     <= '0;
      dump_valid_q <= 1'b0;
      dump_index_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reason_q     <= reason_d;
      rd_cnt_q     <= rd_cnt_d;
      dump_valid_q <= mem_rd_en;
      dump_index_q <= mem_rd_en ? rd_cnt_q[ADDR_W-1:0] : '0;
    end
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: scoreboard bench over three parameterisations of run_controller
module tb_run_controller;
  typedef struct packed {int inst; logic [15:0] idx; logic [15:0] data;} ditem_t;
  typedef struct packed {int inst; logic [15:0] addr;} aitem_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_s [3];
  logic        abort_s [3];
  logic [15:0] pc_s    [3];
  logic [15:0] rdd     [3];
  logic        cpu_run_w [3];
  logic        rd_en_w   [3];
  logic [15:0] rd_addr_w [3];
  logic        dv_w      [3];
  logic [15:0] di_w      [3];
  logic [15:0] dd_w      [3];
  logic [31:0] cc_w      [3];
  logic        done_w    [3];
  logic [1:0]  reason_w  [3];
  int          len_p  [3] = '{10, 4, 0};
  int          base_p [3] = '{0, 16'hFFFE, 0};
  int          errors = 0;
  int          checks = 0;
  ditem_t      dq [$];
  aitem_t      aq [$];
  ditem_t      de;
  aitem_t      ae;
  always #5 clk = ~clk;
  run_controller #(.MAX_CYCLES(10), .HALT_REPEAT(4), .DUMP_BASE(0), .DUMP_LEN(10)) u_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .pc(pc_s[0]),
    .mem_rd_data(rdd[0]), .cpu_run(cpu_run_w[0]), .mem_rd_en(rd_en_w[0]),
    .mem_rd_addr(rd_addr_w[0]), .dump_valid(dv_w[0]), .dump_index(di_w[0]),
    .dump_data(dd_w[0]), .cycle_count(cc_w[0]), .done(done_w[0]), .stop_reason(reason_w[0]));
  run_controller #(.MAX_CYCLES(0), .HALT_REPEAT(2), .DUMP_BASE(16'hFFFE), .DUMP_LEN(4)) u_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .pc(pc_s[1]),
    .mem_rd_data(rdd[1]), .cpu_run(cpu_run_w[1]), .mem_rd_en(rd_en_w[1]),
    .mem_rd_addr(rd_addr_w[1]), .dump_valid(dv_w[1]), .dump_index(di_w[1]),
    .dump_data(dd_w[1]), .cycle_count(cc_w[1]), .done(done_w[1]), .stop_reason(reason_w[1]));
  run_controller #(.MAX_CYCLES(5), .HALT_REPEAT(0), .DUMP_BASE(0), .DUMP_LEN(0)) u_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .abort(abort_s[2]), .pc(pc_s[2]),
    .mem_rd_data(rdd[2]), .cpu_run(cpu_run_w[2]), .mem_rd_en(rd_en_w[2]),
    .mem_rd_addr(rd_addr_w[2]), .dump_valid(dv_w[2]), .dump_index(di_w[2]),
    .dump_data(dd_w[2]), .cycle_count(cc_w[2]), .done(done_w[2]), .stop_reason(reason_w[2]));
  function automatic logic [15:0] ram_f(input logic [15:0] a);
    return a == 16'd0 ? 16'd5 : a == 16'd1 ? 16'd3 : a * 16'd7 + 16'h0100;
  endfunction
  function automatic logic [15:0] pat(input int mode, input int j);
    return mode == 0 ? 16'(j) : mode == 1 ? (j < 3 ? 16'(4 + j) : 16'd7) : 16'h0020;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk)
    for (int k = 0; k < 3; k++) rdd[k] <= rd_en_w[k] ? ram_f(rd_addr_w[k]) : 16'h0;
  always @(negedge clk)
    if (rst)
      for (int k = 0; k < 3; k++) begin
        if (rd_en_w[k]) begin
          if (aq.size() == 0) chk("unexpected_rd", 64'(k), 64'hFF);
          else begin
            ae = aq.pop_front();
            chk("rd_addr", {32'(k), 16'h0, rd_addr_w[k]}, {32'(ae.inst), 16'h0, ae.addr});
          end
        end
        if (dv_w[k]) begin
          if (dq.size() == 0) chk("unexpected_dump", 64'(k), 64'hFF);
          else begin
            de = dq.pop_front();
            chk("dump_item", {32'(k), di_w[k], dd_w[k]}, {32'(de.inst), de.idx, de.data});
          end
        end
      end
  task automatic run(input int i, input int mode, input int abort_at,
                     input int exp_reason, input int exp_cnt, input int rst_at);
    int runs = 0;
    int lat  = 0;
    int exp_lat = exp_cnt + (len_p[i] != 0 ? len_p[i] + 2 : 1);
    logic [15:0] a;
    for (int n = 0; n < len_p[i]; n++) begin
      a = 16'(base_p[i] + n);
      aq.push_back('{i, a});
      dq.push_back('{i, 16'(n), ram_f(a)});
    end
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    chk("start_clears_count", 64'(cc_w[i]), 64'd0);
    chk("start_clears_done", 64'(done_w[i]), 64'd0);
    chk("start_clears_reason", 64'(reason_w[i]), 64'd0);
    for (int j = 1; j <= 300 && lat == 0; j++) begin
      if (j == rst_at) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_outputs", {cpu_run_w[i], rd_en_w[i], rd_addr_w[i], dv_w[i], di_w[i], dd_w[i],
                            done_w[i], reason_w[i]}, 64'd0);
        chk("rst_count", 64'(cc_w[i]), 64'd0);
        aq.delete();
        dq.delete();
        abort_s[i] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      if (done_w[i]) lat = j;
      else begin
        runs += int'(cpu_run_w[i]);
        pc_s[i]    = pat(mode, j);
        abort_s[i] = (j == abort_at);
        @(negedge clk);
      end
    end
    abort_s[i] = 1'b0;
    if (lat == 0) chk("done_timeout", 64'd0, 64'd1);
    chk("stop_reason", 64'(reason_w[i]), 64'(exp_reason));
    chk("cycle_count", 64'(cc_w[i]), 64'(exp_cnt));
    chk("cpu_run_cycles", 64'(runs), 64'(exp_cnt));
    chk("done_latency", 64'(lat), 64'(exp_lat));
    chk("dump_drained", 64'(dq.size() + aq.size()), 64'd0);
    abort_s[i] = 1'b1;
    @(negedge clk);
    abort_s[i] = 1'b0;
    chk("done_held", {done_w[i], reason_w[i], cc_w[i]}, {1'b1, 2'(exp_reason), 32'(exp_cnt)});
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      abort_s[k] = 1'b0;
      pc_s[k]    = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_state", {cpu_run_w[k], rd_en_w[k], rd_addr_w[k], dv_w[k], di_w[k], dd_w[k],
                          done_w[k], reason_w[k], 6'h0} | 64'(cc_w[k]), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    run(0, 0, 0, 1, 10, 0);
    run(0, 1, 0, 2, 7, 0);
    run(1, 2, 3, 3, 3, 0);
    run(1, 2, 0, 2, 3, 0);
    run(2, 0, 0, 1, 5, 0);
    run(2, 0, 0, 1, 5, 0);
    run(0, 0, 0, 1, 10, 13);
    run(0, 0, 0, 1, 10, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
